// File: rtl/systolic_pkg.sv
// Shared types and default dimensions for the systolic tile and its edge feeders.
package systolic_pkg;

  localparam int unsigned DefNLanes = 8;
  localparam int unsigned DefDataW  = 16;
  localparam int unsigned DefDepth  = 8;
  localparam int unsigned DefDrain  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLoaded,
    StStream,
    StDrain
  } feeder_state_t;

endpackage

// File: rtl/systolic_edge_feeder_if.sv
// Load/control/array-edge bundle of one edge feeder; master drives loads and commands.
interface systolic_edge_feeder_if
  import systolic_pkg::*;
#(
  parameter int unsigned N_LANES = DefNLanes,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned DEPTH   = DefDepth
);
  logic                        load_valid;
  logic                        load_ready;
  logic [N_LANES*DATA_W-1:0]   load_data;
  logic                        load_last;
  logic                        start;
  logic                        clear;
  logic                        busy;
  logic                        done;
  logic                        array_en;
  logic [N_LANES*DATA_W-1:0]   edge_data;
  logic [$clog2(DEPTH+1)-1:0]  k_len;

  modport master (
    output load_valid, load_data, load_last, start, clear,
    input  load_ready, busy, done, array_en, edge_data, k_len
  );

  modport slave (
    input  load_valid, load_data, load_last, start, clear,
    output load_ready, busy, done, array_en, edge_data, k_len
  );
endinterface

// File: rtl/skew_delay_line.sv
// LEN-stage shift register for one skewed lane; LEN=0 degenerates to a wire.
module skew_delay_line #(
  parameter int unsigned LEN    = 1,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  if (LEN == 0) begin : g_pass
    logic unused;
    assign unused = ^{clk, rst_n, shift_en, clr};
    assign dout   = din;
  end else begin : g_dly
    logic [DATA_W-1:0] dl_q [LEN];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < int'(LEN); k++) dl_q[k] <= '0;
      end else if (clr) begin
        for (int k = 0; k < int'(LEN); k++) dl_q[k] <= '0;
      end else if (shift_en) begin
        dl_q[0] <= din;
        for (int k = 1; k < int'(LEN); k++) dl_q[k] <= dl_q[k-1];
      end
    end

    assign dout = dl_q[LEN-1];
  end

endmodule

// File: rtl/systolic_edge_feeder.sv
// Buffers up to DEPTH unskewed vectors and replays them into one systolic array edge,
// lane i delayed i cycles, followed by DRAIN enable-only cycles and a DONE pulse.
module systolic_edge_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N_LANES = DefNLanes,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned DRAIN   = DefDrain
) (
  input logic                  clk,
  input logic                  rst_n,
  systolic_edge_feeder_if.slave bus
);

  localparam int unsigned W  = N_LANES * DATA_W;
  localparam int unsigned KW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(DEPTH + N_LANES + DRAIN + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  feeder_state_t   state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [CW-1:0]   s_q, s_d;
  logic [W-1:0]    row_q, row_d;
  logic            array_en_q, array_en_d;
  logic            done_q, done_d;
  logic            wr_en, dl_clr, xfer;
  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    edge_data;
  logic [CW-1:0]   next_s, k_ext, stream_last, run_last;

  assign bus.load_ready = (state_q == StIdle) || (state_q == StLoad);
  assign xfer           = bus.load_valid && bus.load_ready;

  assign k_ext       = CW'(k_len_q);
  assign next_s      = s_q + CW'(1);
  assign stream_last = k_ext + CW'(N_LANES - 2);
  assign run_last    = stream_last + CW'(DRAIN);

  always_comb begin
    state_d    = state_q;
    k_len_d    = k_len_q;
    s_d        = s_q;
    row_d      = '0;
    array_en_d = 1'b0;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    dl_clr     = 1'b0;
    unique case (state_q)
      StIdle, StLoad: begin
        if (bus.clear) begin
          state_d = StIdle;
          k_len_d = '0;
        end else if (xfer) begin
          wr_en   = 1'b1;
          k_len_d = k_len_q + KW'(1);
          state_d = (bus.load_last || k_len_q == KW'(DEPTH - 1)) ? StLoaded : StLoad;
        end
      end
      StLoaded: begin
        if (bus.clear) begin
          state_d = StIdle;
          k_len_d = '0;
        end else if (bus.start) begin
          state_d    = StStream;
          s_d        = '0;
          row_d      = mem_q[0];
          array_en_d = 1'b1;
          dl_clr     = 1'b1;
        end
      end
      StStream, StDrain: begin
        s_d        = next_s;
        array_en_d = 1'b1;
        row_d      = (next_s < k_ext) ? mem_q[next_s[IW-1:0]] : '0;
        if (s_q == run_last) begin
          // Flush the skew lines so the edge reads zero while idle.
          state_d    = StLoaded;
          array_en_d = 1'b0;
          done_d     = 1'b1;
          row_d      = '0;
          dl_clr     = 1'b1;
        end else if (state_q == StStream && s_q == stream_last) begin
          state_d = StDrain;
        end
      end
      default: begin
        state_d = StIdle;
        k_len_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      k_len_q    <= '0;
      s_q        <= '0;
      row_q      <= '0;
      array_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_len_q    <= k_len_d;
      s_q        <= s_d;
      row_q      <= row_d;
      array_en_q <= array_en_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[k_len_q[IW-1:0]] <= bus.load_data;
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    skew_delay_line #(
      .LEN    (i),
      .DATA_W (DATA_W)
    ) u_dly (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (array_en_q),
      .clr      (dl_clr),
      .din      (row_q[i*DATA_W +: DATA_W]),
      .dout     (edge_data[i*DATA_W +: DATA_W])
    );
  end

  assign bus.edge_data = edge_data;
  assign bus.array_en  = array_en_q;
  assign bus.busy      = array_en_q;
  assign bus.done      = done_q;
  assign bus.k_len     = k_len_q;

endmodule
